ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands and funct3 leaving the ID/EX pipeline register and computes one bit per cycle. While it works, it raises a stall to the hazard unit. It presents a result for one cycle so the EX/MEM register can capture it.

---
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Execute-stage handshake between the ID/EX pipeline register and the
// iterative multiply/divide unit.
interface ex_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             flush;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs1_data;
   logic [WIDTH-1:0] rs2_data;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, flush, op, rs1_data, rs2_data,
      input  stall, busy, done, result
   );

   modport slave (
      input  start, flush, op, rs1_data, rs2_data,
      output stall, busy, done, result
   );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign fixed at the end.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               neg_res;
   logic               neg_rem;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   result_q;

   logic               accept;
   logic               is_div_in;
   logic               a_signed_in;
   logic               b_signed_in;
   logic               a_neg_in;
   logic               b_neg_in;
   logic [WIDTH-1:0]   a_mag_in;
   logic [WIDTH-1:0]   b_mag_in;
   logic               div_zero;
   logic               div_ovf;
   logic               fast;
   logic [WIDTH-1:0]   fast_result;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] iter_next;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_signed;
   logic [WIDTH-1:0]   rem_signed;
   logic [WIDTH-1:0]   calc_result;

   // Operand decode for the accept cycle; divide-by-zero and the signed
   // overflow case bypass the iteration entirely.
   always_comb begin
      accept      = bus.start & ~bus.flush & (state != CALC);
      is_div_in   = bus.op[2];
      a_signed_in = is_div_in ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
      b_signed_in = is_div_in ? ~bus.op[0] : ~bus.op[1];
      a_neg_in    = a_signed_in & bus.rs1_data[WIDTH-1];
      b_neg_in    = b_signed_in & bus.rs2_data[WIDTH-1];
      a_mag_in    = a_neg_in ? -bus.rs1_data : bus.rs1_data;
      b_mag_in    = b_neg_in ? -bus.rs2_data : bus.rs2_data;
      div_zero    = is_div_in & (bus.rs2_data == '0);
      div_ovf     = is_div_in & ~bus.op[0] & (bus.rs1_data == MIN_NEG) & (bus.rs2_data == '1);
      fast        = div_zero | div_ovf;
      if (div_zero)
         fast_result = bus.op[1] ? bus.rs1_data : '1;
      else
         fast_result = bus.op[1] ? '0 : MIN_NEG;
   end

   // One iteration step; multiply and divide share the double-width accumulator.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : '0)};
      div_trial = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_trial - {1'b0, b_mag};
      if (op_q[2]) begin
         if (div_diff[WIDTH])
            iter_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            iter_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         iter_next = {mul_sum, acc[WIDTH-1:1]};
      end
      prod_signed = neg_res ? -iter_next : iter_next;
      quo_signed  = neg_res ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];
      rem_signed  = neg_rem ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];
      if (op_q[2])
         calc_result = op_q[1] ? rem_signed : quo_signed;
      else if (op_q[1:0] == 2'b00)
         calc_result = prod_signed[WIDTH-1:0];
      else
         calc_result = prod_signed[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (bus.flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept)
                  state_next = fast ? DONE : CALC;
               else
                  state_next = IDLE;
            end
            CALC: begin
               if (cnt == LAST)
                  state_next = DONE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy   = (state == CALC);
      bus.done   = (state == DONE);
      bus.stall  = (bus.start & ~bus.flush & (state != DONE)) | (state == CALC);
      bus.result = result_q;
   end

   // A flushed cycle leaves every register untouched, so the previous result survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         op_q     <= '0;
         a_mag    <= '0;
         b_mag    <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         acc      <= '0;
         result_q <= '0;
      end else if (!bus.flush) begin
         if (accept) begin
            cnt     <= '0;
            op_q    <= bus.op;
            a_mag   <= a_mag_in;
            b_mag   <= b_mag_in;
            neg_res <= a_neg_in ^ b_neg_in;
            neg_rem <= a_neg_in;
            acc     <= is_div_in ? {{WIDTH{1'b0}}, a_mag_in} : {{WIDTH{1'b0}}, b_mag_in};
            if (fast)
               result_q <= fast_result;
         end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
            acc <= iter_next;
            if (cnt == LAST)
               result_q <= calc_result;
         end
      end
   end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, flush/reset
// aborts, back-to-back issue and randomized operations against an arithmetic model.
module tb_ex_muldiv;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;
   localparam logic [31:0] ALL1    = 32'hFFFF_FFFF;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   ex_muldiv_if #(.WIDTH(32)) bus ();

   ex_muldiv #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      string       tag;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] sa;
      logic [63:0] sb;
      logic [63:0] p;
      if (!op[2]) begin
         sa = (op != 3'd3) ? {{32{a[31]}}, a} : {32'b0, a};
         sb = (op <= 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
         p  = sa * sb;
         return (op == 3'd0) ? p[31:0] : p[63:32];
      end
      if (b == 0) return op[1] ? a : ALL1;
      if (!op[0] && a == MIN_NEG && b == ALL1) return op[1] ? 32'd0 : MIN_NEG;
      case (op)
         3'd4:    return $signed(a) / $signed(b);
         3'd5:    return a / b;
         3'd6:    return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (op[2] && (b == 0 || (!op[0] && a == MIN_NEG && b == ALL1))) return 1;
      return 33;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // Drive an instruction into the accept cycle and check the combinational stall.
   task automatic apply_stimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic exp_stall);
      bus.op       = op;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.start    = 1'b1;
      #1;
      check({tag, " accept stall"}, {31'b0, bus.stall}, {31'b0, exp_stall});
   endtask

   // Count cycles from the accept cycle to done, bounded, checking stall/busy on the way.
   task automatic check_output(input string tag, input logic [31:0] exp_res, input int exp_lat);
      int   n;
      logic stall_bad;
      n         = 1;
      stall_bad = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      #1;
      while (bus.done !== 1'b1 && n < 40) begin
         if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stall_bad = 1'b1;
         @(posedge clk);
         #2;
         n++;
      end
      check({tag, " latency"}, n, exp_lat);
      check({tag, " result"}, bus.result, exp_res);
      check({tag, " stall/busy during calc"}, {31'b0, stall_bad}, 32'd0);
      check({tag, " stall at done"}, {31'b0, bus.stall}, 32'd0);
      check({tag, " busy at done"}, {31'b0, bus.busy}, 32'd0);
   endtask

   task automatic expect_no_done(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         if (bus.done === 1'b1) seen = 1'b1;
         @(posedge clk);
         #2;
      end
      check({tag, " no done"}, {31'b0, seen}, 32'd0);
   endtask

   vec_t        dir[$];
   logic [31:0] last_res;
   logic [2:0]  rop;
   logic [31:0] ra;
   logic [31:0] rb;
   int          sel;

   initial begin
      n_assert     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.flush    = 1'b0;
      bus.op       = 3'd0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset busy", {31'b0, bus.busy}, 32'd0);
      check("reset done", {31'b0, bus.done}, 32'd0);
      check("reset stall", {31'b0, bus.stall}, 32'd0);
      check("reset result", bus.result, 32'd0);

      dir.push_back('{"MUL 7*-3",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
      dir.push_back('{"MULH 7*-3",    3'd1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33});
      dir.push_back('{"MULHU max",    3'd3, ALL1,         ALL1,          32'hFFFF_FFFE, 33});
      dir.push_back('{"MULHSU max",   3'd2, ALL1,         ALL1,          32'hFFFF_FFFF, 33});
      dir.push_back('{"DIV -7/2",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33});
      dir.push_back('{"REM -7/2",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33});
      dir.push_back('{"DIVU 100/7",   3'd5, 32'd100,      32'd7,         32'd14,        33});
      dir.push_back('{"REMU 100/7",   3'd7, 32'd100,      32'd7,         32'd2,         33});
      dir.push_back('{"DIV ovf",      3'd4, MIN_NEG,      ALL1,          MIN_NEG,       1});
      dir.push_back('{"REM ovf",      3'd6, MIN_NEG,      ALL1,          32'd0,         1});
      dir.push_back('{"DIV 5/0",      3'd4, 32'd5,        32'd0,         ALL1,          1});
      dir.push_back('{"REMU 5/0",     3'd7, 32'd5,        32'd0,         32'd5,         1});

      @(posedge clk);
      #2;
      foreach (dir[i]) begin
         apply_stimulus(dir[i].tag, dir[i].op, dir[i].a, dir[i].b, 1'b1);
         check_output(dir[i].tag, dir[i].exp, dir[i].lat);
         @(posedge clk);
         #2;
      end
      last_res = 32'd5;

      // Flush in the fifth cycle after acceptance aborts the divide silently.
      apply_stimulus("flush DIVU", 3'd5, 32'd1000, 32'd3, 1'b1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      #1;
      check("flush busy", {31'b0, bus.busy}, 32'd0);
      check("flush done", {31'b0, bus.done}, 32'd0);
      expect_no_done("flush", 40);
      check("flush result kept", bus.result, last_res);

      // Start coinciding with flush must be ignored.
      bus.op       = 3'd4;
      bus.rs1_data = 32'd10;
      bus.rs2_data = 32'd2;
      bus.start    = 1'b1;
      bus.flush    = 1'b1;
      #1;
      check("start+flush stall", {31'b0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      #1;
      check("start+flush busy", {31'b0, bus.busy}, 32'd0);
      expect_no_done("start+flush", 5);
      check("start+flush result kept", bus.result, last_res);

      // Back-to-back: a new start in the DONE cycle keeps the old result visible.
      apply_stimulus("b2b DIVU", 3'd5, 32'd100, 32'd7, 1'b1);
      check_output("b2b DIVU", 32'd14, 33);
      apply_stimulus("b2b MUL", 3'd0, 32'd3, 32'd4, 1'b0);
      check("b2b old result visible", bus.result, 32'd14);
      check_output("b2b MUL", 32'd12, 33);
      @(posedge clk);
      #2;

      // Asynchronous reset ten cycles into a multiply.
      apply_stimulus("reset mid", 3'd0, 32'h0000_1234, 32'd5, 1'b1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset mid busy", {31'b0, bus.busy}, 32'd0);
      check("reset mid done", {31'b0, bus.done}, 32'd0);
      check("reset mid result", bus.result, 32'd0);
      expect_no_done("reset mid", 40);

      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 32'd0;
         else if (sel == 1) begin
            ra = MIN_NEG;
            rb = ALL1;
         end else if (sel == 2) rb = 32'($urandom_range(1, 15));
         else if (sel == 3) ra = 32'($urandom_range(0, 1000));
         apply_stimulus($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'b1);
         check_output($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb),
                      ref_model(rop, ra, rb), ref_latency(rop, ra, rb));
         @(posedge clk);
         #2;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
